timer_controller: RTL and testbench

//  Sequencing controller for the stopwatch datapath. Samples the slow scaledclk output of the

---
 rtl/timer_pkg.sv | 72 +++++++
 rtl/edge_sync.sv | 37 +++
 rtl/timer_controller.sv | 141 ++++++++++++++
 tb/tb_timer_controller.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the stopwatch timer controller.
// Countdown mode is enabled with the TIMER_COUNTDOWN_EN macro.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } timer_state_t;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t min_tens;
    bcd_t min_ones;
    bcd_t sec_tens;
    bcd_t sec_ones;
  } bcd_time_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t DIGIT_MAX    = 4'd9;

  function automatic int bcd_val(bcd_t t, bcd_t o);
    return 10 * int'(t) + int'(o);
  endfunction

  function automatic bcd_time_t bcd_inc(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != DIGIT_MAX) begin
      r.sec_ones = t.sec_ones + 4'd1;
    end else begin
      r.sec_ones = '0;
      if (t.sec_tens != SEC_TENS_MAX) begin
        r.sec_tens = t.sec_tens + 4'd1;
      end else begin
        r.sec_tens = '0;
        if (t.min_ones != DIGIT_MAX) begin
          r.min_ones = t.min_ones + 4'd1;
        end else begin
          r.min_ones = '0;
          r.min_tens = t.min_tens + 4'd1;
        end
      end
    end
    return r;
  endfunction

  function automatic bcd_time_t bcd_dec(bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != '0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = DIGIT_MAX;
      if (t.sec_tens != '0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = SEC_TENS_MAX;
        if (t.min_ones != '0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = DIGIT_MAX;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Input synchroniser chain followed by a registered rising-edge
// detector producing a one-cycle pulse.
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  localparam int FW = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [FW-1:0]          fill;
  logic                   full;

  assign full = (fill == FW'(SYNC_STAGES));

  // prev is held high until the chain has refilled after reset,
  // so a level already high at reset release is not an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '0;
      prev <= 1'b1;
      fill <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      if (!full) fill <= fill + 1'b1;
      prev <= full ? sync[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign pulse = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/timer_controller.sv
// Stopwatch sequencing controller: tick/button edges into a BCD mm:ss counter.
// Define TIMER_COUNTDOWN_EN for preset load and count-down operation.
module timer_controller
  import timer_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MIN     = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scaledclk,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       done
);

  localparam bcd_t MAX_T = bcd_t'(MAX_MIN / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX_MIN % 10);

  timer_state_t state, state_n;
  bcd_time_t    cnt, cnt_n;
  logic         tick, ss_p, clr_p;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clock(clock), .reset(reset),
    .d(scaledclk), .pulse(tick)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clock(clock), .reset(reset),
    .d(start_stop), .pulse(ss_p)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clock(clock), .reset(reset),
    .d(clear), .pulse(clr_p)
  );

`ifdef TIMER_COUNTDOWN_EN
  logic      ld_p;
  logic      is_zero;
  bcd_time_t preset;
  bcd_t      p_mo;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ld (
    .clock(clock), .reset(reset),
    .d(load), .pulse(ld_p)
  );

  assign is_zero = (cnt == '0);

  always_comb begin
    preset = '0;
    p_mo   = (preset_min[3:0] > DIGIT_MAX) ?
             DIGIT_MAX : preset_min[3:0];
    if (preset_sec[7:4] > SEC_TENS_MAX) begin
      preset.sec_tens = SEC_TENS_MAX;
      preset.sec_ones = DIGIT_MAX;
    end else begin
      preset.sec_tens = preset_sec[7:4];
      preset.sec_ones = (preset_sec[3:0] > DIGIT_MAX) ?
                        DIGIT_MAX : preset_sec[3:0];
    end
    if (bcd_val(preset_min[7:4], p_mo) > MAX_MIN) begin
      preset.min_tens = MAX_T;
      preset.min_ones = MAX_O;
    end else begin
      preset.min_tens = preset_min[7:4];
      preset.min_ones = p_mo;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{load, preset_min, preset_sec};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (clr_p) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE, PAUSE: begin
`ifdef TIMER_COUNTDOWN_EN
          if (ld_p) cnt_n = preset;
          if (ss_p && !is_zero) state_n = RUN;
`else
          if (ss_p) state_n = RUN;
`endif
        end
        RUN: begin
          if (ss_p) state_n = PAUSE;
          if (tick) begin
`ifdef TIMER_COUNTDOWN_EN
            cnt_n = bcd_dec(cnt);
            if (cnt_n == '0) state_n = DONE;
`else
            // The terminal tick leaves the count at MAX_MIN:59.
            if (cnt == {MAX_T, MAX_O, SEC_TENS_MAX, DIGIT_MAX})
              state_n = DONE;
            else
              cnt_n = bcd_inc(cnt);
`endif
          end
        end
        DONE: begin
          state_n = DONE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign sec_ones = cnt.sec_ones;
  assign sec_tens = cnt.sec_tens;
  assign min_ones = cnt.min_ones;
  assign min_tens = cnt.min_tens;
  assign running  = (state == RUN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_timer_controller.sv
// Directed self-checking bench for timer_controller.
// Instance a uses MAX_MIN=99, instance b uses MAX_MIN=1.
module tb_timer_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       scaledclk;
  logic       start_stop;
  logic       clear;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;

  logic [3:0] a_so, a_st, a_mo, a_mt;
  logic [3:0] b_so, b_st, b_mo, b_mt;
  logic       a_run, a_done, b_run, b_done;
  logic [15:0] ta, tb;

  int checks = 0;
  int failures = 0;

  assign ta = {a_mt, a_mo, a_st, a_so};
  assign tb = {b_mt, b_mo, b_st, b_so};

  always #5 clock = ~clock;

  timer_controller #(.SYNC_STAGES(2), .MAX_MIN(99)) dut_a (
    .clock(clock), .reset(reset), .scaledclk(scaledclk),
    .start_stop(start_stop), .clear(clear), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .sec_ones(a_so), .sec_tens(a_st),
    .min_ones(a_mo), .min_tens(a_mt),
    .running(a_run), .done(a_done)
  );

  timer_controller #(.SYNC_STAGES(2), .MAX_MIN(1)) dut_b (
    .clock(clock), .reset(reset), .scaledclk(scaledclk),
    .start_stop(start_stop), .clear(clear), .load(load),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .sec_ones(b_so), .sec_tens(b_st),
    .min_ones(b_mo), .min_tens(b_mt),
    .running(b_run), .done(b_done)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      scaledclk = 1'b1;
      cyc(4);
      scaledclk = 1'b0;
      cyc(4);
    end
  endtask

  task automatic press_ss();
    start_stop = 1'b1;
    cyc(4);
    start_stop = 1'b0;
    cyc(4);
  endtask

  task automatic press_clr();
    clear = 1'b1;
    cyc(4);
    clear = 1'b0;
    cyc(4);
  endtask

  task automatic press_ld();
    load = 1'b1;
    cyc(4);
    load = 1'b0;
    cyc(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    scaledclk = 0; start_stop = 0; clear = 0; load = 0;
    preset_min = 8'h00; preset_sec = 8'h00;
    cyc(3);
    reset = 1'b0;
    cyc(4);
    if (ta !== 16'h0000) begin
      failures++;
      $display("FAIL reset_digits got=%h exp=%h", ta, 16'h0000);
    end
    checks++;
    if ({a_run, a_done} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=%b", {a_run, a_done}, 2'b00);
    end
    checks++;
  endtask

  task automatic test_count_up();
    press_ss();
    if (a_run !== 1'b1) begin
      failures++;
      $display("FAIL t1_start got=%b exp=1", a_run);
    end
    checks++;
    // first tick: sampled at edge 1, digits move on edge 3
    scaledclk = 1'b1;
    cyc(2);
    if (ta !== 16'h0000) begin
      failures++;
      $display("FAIL t1_latency_early got=%h exp=%h", ta, 16'h0000);
    end
    checks++;
    cyc(1);
    if (ta !== 16'h0001) begin
      failures++;
      $display("FAIL t1_latency got=%h exp=%h", ta, 16'h0001);
    end
    checks++;
    cyc(1);
    scaledclk = 1'b0;
    cyc(4);
    tick(60);
    if (ta !== 16'h0101) begin
      failures++;
      $display("FAIL t1_count got=%h exp=%h", ta, 16'h0101);
    end
    checks++;
    if ({a_run, a_done} !== 2'b10) begin
      failures++;
      $display("FAIL t1_flags got=%b exp=%b", {a_run, a_done}, 2'b10);
    end
    checks++;
  endtask

  task automatic test_pause();
    press_clr();
    press_ss();
    tick(37);
    if (ta !== 16'h0037) begin
      failures++;
      $display("FAIL t2_reach got=%h exp=%h", ta, 16'h0037);
    end
    checks++;
    press_ss();
    tick(5);
    if (ta !== 16'h0037) begin
      failures++;
      $display("FAIL t2_hold got=%h exp=%h", ta, 16'h0037);
    end
    checks++;
    if (a_run !== 1'b0) begin
      failures++;
      $display("FAIL t2_paused got=%b exp=0", a_run);
    end
    checks++;
    press_ss();
    tick(1);
    if (ta !== 16'h0038) begin
      failures++;
      $display("FAIL t2_resume got=%h exp=%h", ta, 16'h0038);
    end
    checks++;
  endtask

  task automatic test_terminal();
    press_clr();
    press_ss();
    tick(119);
    if (tb !== 16'h0159 || b_run !== 1'b1) begin
      failures++;
      $display("FAIL t3_reach got=%h run=%b exp=%h run=1",
               tb, b_run, 16'h0159);
    end
    checks++;
    tick(1);
    if (tb !== 16'h0159) begin
      failures++;
      $display("FAIL t3_hold got=%h exp=%h", tb, 16'h0159);
    end
    checks++;
    if ({b_run, b_done} !== 2'b01) begin
      failures++;
      $display("FAIL t3_done got=%b exp=%b", {b_run, b_done}, 2'b01);
    end
    checks++;
    if (ta !== 16'h0200) begin
      failures++;
      $display("FAIL t3_carry got=%h exp=%h", ta, 16'h0200);
    end
    checks++;
    press_ss();
    tick(2);
    if (tb !== 16'h0159 || b_done !== 1'b1) begin
      failures++;
      $display("FAIL t3_ignore got=%h done=%b exp=%h done=1",
               tb, b_done, 16'h0159);
    end
    checks++;
    press_clr();
    if (tb !== 16'h0000 || {b_run, b_done} !== 2'b00) begin
      failures++;
      $display("FAIL t3_clear got=%h flags=%b exp=%h flags=00",
               tb, {b_run, b_done}, 16'h0000);
    end
    checks++;
  endtask

  task automatic test_clear_tick();
    press_clr();
    press_ss();
    tick(10);
    if (ta !== 16'h0010) begin
      failures++;
      $display("FAIL t4_reach got=%h exp=%h", ta, 16'h0010);
    end
    checks++;
    clear = 1'b1;
    scaledclk = 1'b1;
    cyc(4);
    clear = 1'b0;
    scaledclk = 1'b0;
    cyc(4);
    if (ta !== 16'h0000 || {a_run, a_done} !== 2'b00) begin
      failures++;
      $display("FAIL t4_clear got=%h flags=%b exp=%h flags=00",
               ta, {a_run, a_done}, 16'h0000);
    end
    checks++;
    tick(3);
    if (ta !== 16'h0000) begin
      failures++;
      $display("FAIL t4_idle_tick got=%h exp=%h", ta, 16'h0000);
    end
    checks++;
  endtask

  task automatic test_load();
    press_clr();
    preset_min = 8'h01;
    preset_sec = 8'h00;
    press_ld();
`ifdef TIMER_COUNTDOWN_EN
    if (ta !== 16'h0100) begin
      failures++;
      $display("FAIL t5_load got=%h exp=%h", ta, 16'h0100);
    end
    checks++;
    press_ss();
    tick(1);
    if (ta !== 16'h0059) begin
      failures++;
      $display("FAIL t5_first got=%h exp=%h", ta, 16'h0059);
    end
    checks++;
    tick(59);
    if (ta !== 16'h0000 || {a_run, a_done} !== 2'b01) begin
      failures++;
      $display("FAIL t5_zero got=%h flags=%b exp=%h flags=01",
               ta, {a_run, a_done}, 16'h0000);
    end
    checks++;
    press_clr();
    preset_min = 8'h05;
    preset_sec = 8'h77;
    press_ld();
    if (tb !== 16'h0159) begin
      failures++;
      $display("FAIL t5_clamp got=%h exp=%h", tb, 16'h0159);
    end
    checks++;
`else
    if (ta !== 16'h0000) begin
      failures++;
      $display("FAIL t5_noload got=%h exp=%h", ta, 16'h0000);
    end
    checks++;
`endif
    press_clr();
  endtask

  task automatic test_reset_mid();
    press_ss();
    tick(42);
    if (ta !== 16'h0042) begin
      failures++;
      $display("FAIL t6_reach got=%h exp=%h", ta, 16'h0042);
    end
    checks++;
    start_stop = 1'b1;
    reset = 1'b1;
    cyc(1);
    if (ta !== 16'h0000 || a_run !== 1'b0) begin
      failures++;
      $display("FAIL t6_reset got=%h run=%b exp=%h run=0",
               ta, a_run, 16'h0000);
    end
    checks++;
    cyc(1);
    reset = 1'b0;
    cyc(10);
    if (a_run !== 1'b0) begin
      failures++;
      $display("FAIL t6_held_level got=%b exp=0", a_run);
    end
    checks++;
    start_stop = 1'b0;
    cyc(4);
    press_ss();
    if (a_run !== 1'b1) begin
      failures++;
      $display("FAIL t6_restart got=%b exp=1", a_run);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_pause();
    test_terminal();
    test_clear_tick();
    test_load();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
